fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined core. It owns the program counter and drives the instruction-memory address. It captures the fetched word into the IF/ID pipeline register and applies the branch predictor's `next_pc`/`clear_if` together with the execute stage's misprediction redirect. It sits directly upstream of the jump predictor and feeds it `next_consecutive_pc` and the IF/ID contents it decodes.

## Interface

Parameters:
- `PC_SIZE`, 12: PC / byte-address width.
- `RESET_PC`, 0: PC value loaded on reset; must be 4-byte aligned.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RESET_N`  in  1  reset, **synchronous, active-low**.
- `stall`  in  1  hazard unit: hold PC and IF/ID.
- `next_pc`  in  PC_SIZE  predictor target, used only when `clear_if`=1.
- `clear_if`  in  1  predictor: ID holds a branch; flush the IF slot and load `next_pc`.
- `redirect_valid`  in  1  EX: misprediction detected.
- `redirect_pc`  in  PC_SIZE  EX: corrected PC.
- `imem_addr`  out  PC_SIZE  byte address to instruction memory (= PC).
- `imem_en`  out  1  fetch enable.
- `imem_rdata`  in  32  instruction word; combinational read of `imem_addr`.
- `next_consecutive_pc`  out  PC_SIZE  `if_id_pc + 4`, to predictor.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `if_id_pc`  out  PC_SIZE  PC of IF/ID instruction.
- `if_id_instr`  out  32  IF/ID instruction (NOP when invalid).
- `fetch_count`  out  CNT_W  valid instructions captured, saturating.
- `flush_count`  out  CNT_W  bubbles inserted by `clear_if` or redirect, saturating.

## Operation

FSM states:
- BOOT: entered on reset; lasts exactly one cycle.
  - `imem_en`=0, PC held, IF/ID stays invalid.
  - Then goes to RUN unconditionally.
- RUN: normal fetch; `imem_en`=1.

PC update in RUN, highest priority first:
1. `redirect_valid` → PC ← `redirect_pc`.
2. `stall` → PC held.
3. `clear_if` → PC ← `next_pc`.
4. Otherwise → PC ← PC + 4.

IF/ID update in RUN, same priority order:
1. `redirect_valid` → `if_id_valid`←0, `if_id_instr`←NOP (0x00000013), `if_id_pc`←`redirect_pc`.
2. `stall` → IF/ID held.
3. `clear_if` → `if_id_valid`←0, instr←NOP, `if_id_pc`←`next_pc`.
4. Otherwise → `if_id_valid`←1, `if_id_instr`←`imem_rdata`, `if_id_pc`←PC.

Other rules:
- `redirect_valid` overrides `stall` in the same cycle; a redirect is never lost.
- Arithmetic: PC + 4 wraps modulo 2^PC_SIZE (0xFFC + 4 = 0x000 for PC_SIZE=12). `next_consecutive_pc` wraps the same way.
- Counters:
  - `fetch_count` +1 on each edge that loads a valid instruction (rule 4).
  - `flush_count` +1 on each edge applying rule 1 or 3.
  - Both saturate at 2^CNT_W−1 and hold there.
- Misaligned `redirect_pc`/`next_pc`: low two bits are forced to 0 when loaded.

## Timing

- Reset values (on an edge with `RESET_N`=0):
  - PC=`RESET_PC`
  - state=BOOT
  - `if_id_valid`=0, `if_id_instr`=NOP, `if_id_pc`=`RESET_PC`
  - both counters 0
  - `imem_en`=0
- Combinational outputs track the registered state: `imem_addr`=PC, `imem_en`=(state==RUN), `next_consecutive_pc`=`if_id_pc`+4.
- Reset mid-operation: `RESET_N` low on any edge overrides every other input.
- First real instruction: with reset released at edge 0, BOOT covers edge 1. Edge 2 captures the word at `RESET_PC` into IF/ID (`if_id_valid`=1 after edge 2).
- Latency: `imem_addr` → `if_id_instr` is one edge.
- Redirect penalty: one bubble. The instruction at `redirect_pc` enters IF/ID on the second edge after `redirect_valid`.
- `clear_if` penalty: one bubble.
- `stall` has no effect in BOOT; inputs other than reset are ignored there.

## Structure

- Shared package `fetch_pkg`:
  - `NOP_INSTR` = 32'h00000013
  - `B_FORMAT_OP_CODE` = 7'b1100011
  - `fetch_state_t` enum {BOOT, RUN}
- Sub-module `if_id_register`: holds valid/pc/instr, with load, hold and bubble controls driven by the parent's priority logic.
- The parent holds the FSM, PC register and counters.

## Test plan

- Reset release, no stall, memory returns the index word:
  - `if_id_valid` rises after edge 2 with `if_id_pc`=0x000.
  - Then 0x004, 0x008 on successive edges.
  - `fetch_count` increments each edge.
- `clear_if`=1 with `next_pc`=0x040 while PC=0x010:
  - one bubble (`if_id_valid`=0, instr=NOP).
  - Next edge captures pc 0x040.
  - `flush_count`=1.
- `stall` held for 3 cycles at PC=0x020: PC, IF/ID and counters unchanged for 3 edges; fetch then resumes at 0x020.
- `redirect_valid` with `redirect_pc`=0x100 and `stall`=1 and `clear_if`=1 on the same edge:
  - PC becomes 0x100, IF/ID gets a bubble, `flush_count` +1.
- PC=0xFFC with no stall: next PC=0x000.
- `RESET_N` low mid-stream: all outputs return to reset values in one edge, then the BOOT/RUN sequence repeats.
- Counter saturation with CNT_W=4: after 20 valid fetches, `fetch_count`=15.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [6:0]  B_FORMAT_OP_CODE = 7'b1100011;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: valid flag, PC and instruction word.
// bubble wins over load; holding is the default when neither is asserted.
module if_id_register
    import fetch_pkg::*;
#(
    parameter int unsigned           PC_SIZE  = 12,
    parameter logic [PC_SIZE-1:0]    RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               load,
    input  logic               bubble,
    input  logic [PC_SIZE-1:0] load_pc,
    input  logic [31:0]        load_instr,
    input  logic [PC_SIZE-1:0] bubble_pc,
    output logic               valid,
    output logic [PC_SIZE-1:0] pc,
    output logic [31:0]        instr
);

    // Capture a fetched word, insert a NOP bubble, or hold.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            valid <= 1'b0;
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
        end else if (bubble) begin
            valid <= 1'b0;
            pc    <= bubble_pc;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN sequencing, IF/ID control
// and saturating performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned           PC_SIZE  = 12,
    parameter logic [PC_SIZE-1:0]    RESET_PC = '0,
    parameter int unsigned           CNT_W    = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               stall,
    input  logic [PC_SIZE-1:0] next_pc,
    input  logic               clear_if,
    input  logic               redirect_valid,
    input  logic [PC_SIZE-1:0] redirect_pc,
    output logic [PC_SIZE-1:0] imem_addr,
    output logic               imem_en,
    input  logic [31:0]        imem_rdata,
    output logic [PC_SIZE-1:0] next_consecutive_pc,
    output logic               if_id_valid,
    output logic [PC_SIZE-1:0] if_id_pc,
    output logic [31:0]        if_id_instr,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   flush_count
);

    localparam logic [PC_SIZE-1:0] ALIGN_MASK = ~PC_SIZE'(3);

    fetch_state_t       state;
    logic [PC_SIZE-1:0] pc;
    logic               run;
    logic               do_redirect;
    logic               do_clear;
    logic               do_load;
    logic [PC_SIZE-1:0] redirect_al;
    logic [PC_SIZE-1:0] next_al;
    logic [PC_SIZE-1:0] bubble_pc;

    // Priority decode: redirect > stall > clear_if > sequential fetch.
    always_comb begin
        run         = (state == RUN);
        redirect_al = redirect_pc & ALIGN_MASK;
        next_al     = next_pc & ALIGN_MASK;
        do_redirect = run && redirect_valid;
        do_clear    = run && !redirect_valid && !stall && clear_if;
        do_load     = run && !redirect_valid && !stall && !clear_if;
        bubble_pc   = redirect_valid ? redirect_al : next_al;
    end

    // FSM and PC register; imem_en is registered alongside the state.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            imem_en <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= RUN;
                    imem_en <= 1'b1;
                end
                RUN: begin
                    if (do_redirect)
                        pc <= redirect_al;
                    else if (do_clear)
                        pc <= next_al;
                    else if (do_load)
                        pc <= pc + PC_SIZE'(4);
                end
                default: begin
                    state   <= BOOT;
                    imem_en <= 1'b0;
                end
            endcase
        end
    end

    // Saturating counters for captured instructions and inserted bubbles.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (do_load && fetch_count != '1)
                fetch_count <= fetch_count + CNT_W'(1);
            if ((do_redirect || do_clear) && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    if_id_register #(
        .PC_SIZE  (PC_SIZE),
        .RESET_PC (RESET_PC)
    ) u_if_id (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .load       (do_load),
        .bubble     (do_redirect || do_clear),
        .load_pc    (pc),
        .load_instr (imem_rdata),
        .bubble_pc  (bubble_pc),
        .valid      (if_id_valid),
        .pc         (if_id_pc),
        .instr      (if_id_instr)
    );

    assign imem_addr           = pc;
    assign next_consecutive_pc = if_id_pc + PC_SIZE'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage (PC_SIZE=12, CNT_W=4).
module tb_fetch_stage;

    localparam int unsigned PC_SIZE = 12;
    localparam int unsigned CNT_W   = 4;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic               CLK = 1'b0;
    logic               RESET_N;
    logic               stall;
    logic [PC_SIZE-1:0] next_pc;
    logic               clear_if;
    logic               redirect_valid;
    logic [PC_SIZE-1:0] redirect_pc;
    logic [PC_SIZE-1:0] imem_addr;
    logic               imem_en;
    logic [31:0]        imem_rdata;
    logic [PC_SIZE-1:0] next_consecutive_pc;
    logic               if_id_valid;
    logic [PC_SIZE-1:0] if_id_pc;
    logic [31:0]        if_id_instr;
    logic [CNT_W-1:0]   fetch_count;
    logic [CNT_W-1:0]   flush_count;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Memory returns a tagged word index so captured words are recognisable.
    assign imem_rdata = 32'hA500_0000 | {22'd0, imem_addr[11:2]};

    fetch_stage #(
        .PC_SIZE  (PC_SIZE),
        .RESET_PC (12'h000),
        .CNT_W    (CNT_W)
    ) dut (
        .CLK                 (CLK),
        .RESET_N             (RESET_N),
        .stall               (stall),
        .next_pc             (next_pc),
        .clear_if            (clear_if),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .imem_addr           (imem_addr),
        .imem_en             (imem_en),
        .imem_rdata          (imem_rdata),
        .next_consecutive_pc (next_consecutive_pc),
        .if_id_valid         (if_id_valid),
        .if_id_pc            (if_id_pc),
        .if_id_instr         (if_id_instr),
        .fetch_count         (fetch_count),
        .flush_count         (flush_count)
    );

    typedef struct {
        logic        rst_n;
        logic        stl;
        logic        clr;
        logic [11:0] npc;
        logic        rdv;
        logic [11:0] rpc;
        logic        e_valid;
        logic [11:0] e_pc;
        logic [31:0] e_instr;
        logic [11:0] e_addr;
        logic        e_en;
        logic [11:0] e_ncpc;
        logic [3:0]  e_fc;
        logic [3:0]  e_flc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_n, input logic stl, input logic clr, input logic [11:0] npc,
        input logic rdv, input logic [11:0] rpc,
        input logic e_valid, input logic [11:0] e_pc, input logic [31:0] e_instr,
        input logic [11:0] e_addr, input logic e_en, input logic [11:0] e_ncpc,
        input logic [3:0] e_fc, input logic [3:0] e_flc);
        vec_t v;
        v.rst_n = rst_n; v.stl = stl; v.clr = clr; v.npc = npc;
        v.rdv = rdv; v.rpc = rpc;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        v.e_addr = e_addr; v.e_en = e_en; v.e_ncpc = e_ncpc;
        v.e_fc = e_fc; v.e_flc = e_flc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic stl, input logic clr,
                        input logic [11:0] npc, input logic rdv, input logic [11:0] rpc);
        RESET_N        = rst_n;
        stall          = stl;
        clear_if       = clr;
        next_pc        = npc;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET_N = 1'b0; stall = 1'b0; clear_if = 1'b0; next_pc = '0;
        redirect_valid = 1'b0; redirect_pc = '0;

        //            rst stl clr npc     rdv rpc      valid pc      instr          addr    en  ncpc    fc  flc
        vecs.push_back(mk(0, 0, 0, 12'h000, 0, 12'h000, 0, 12'h000, NOP,           12'h000, 0, 12'h004, 0, 0)); // reset
        vecs.push_back(mk(1, 1, 1, 12'h200, 1, 12'h300, 0, 12'h000, NOP,           12'h000, 1, 12'h004, 0, 0)); // BOOT ignores inputs
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h000, 32'hA5000000, 12'h004, 1, 12'h004, 1, 0));
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h004, 32'hA5000001, 12'h008, 1, 12'h008, 2, 0));
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h008, 32'hA5000002, 12'h00C, 1, 12'h00C, 3, 0));
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h00C, 32'hA5000003, 12'h010, 1, 12'h010, 4, 0));
        vecs.push_back(mk(1, 0, 1, 12'h040, 0, 12'h000, 0, 12'h040, NOP,           12'h040, 1, 12'h044, 4, 1)); // clear_if at PC 0x010
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h040, 32'hA5000010, 12'h044, 1, 12'h044, 5, 1));
        vecs.push_back(mk(1, 0, 1, 12'h022, 0, 12'h000, 0, 12'h020, NOP,           12'h020, 1, 12'h024, 5, 2)); // misaligned next_pc
        vecs.push_back(mk(1, 1, 0, 12'h000, 0, 12'h000, 0, 12'h020, NOP,           12'h020, 1, 12'h024, 5, 2)); // stall 1
        vecs.push_back(mk(1, 1, 1, 12'h300, 0, 12'h000, 0, 12'h020, NOP,           12'h020, 1, 12'h024, 5, 2)); // stall beats clear_if
        vecs.push_back(mk(1, 1, 0, 12'h000, 0, 12'h000, 0, 12'h020, NOP,           12'h020, 1, 12'h024, 5, 2)); // stall 3
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h020, 32'hA5000008, 12'h024, 1, 12'h024, 6, 2));
        vecs.push_back(mk(1, 1, 1, 12'h200, 1, 12'h100, 0, 12'h100, NOP,           12'h100, 1, 12'h104, 6, 3)); // redirect wins
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h100, 32'hA5000040, 12'h104, 1, 12'h104, 7, 3));
        vecs.push_back(mk(1, 0, 0, 12'h000, 1, 12'hFFE, 0, 12'hFFC, NOP,           12'hFFC, 1, 12'h000, 7, 4)); // misaligned redirect
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h000, 1, 12'hFFC, 32'hA50003FF, 12'h000, 1, 12'h000, 8, 4)); // PC wrap
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h000, 32'hA5000000, 12'h004, 1, 12'h004, 9, 4));
        vecs.push_back(mk(0, 1, 1, 12'h300, 1, 12'h100, 0, 12'h000, NOP,           12'h000, 0, 12'h004, 0, 0)); // mid-stream reset
        vecs.push_back(mk(1, 0, 0, 12'h000, 1, 12'h100, 0, 12'h000, NOP,           12'h000, 1, 12'h004, 0, 0)); // BOOT again
        vecs.push_back(mk(1, 0, 0, 12'h000, 0, 12'h000, 1, 12'h000, 32'hA5000000, 12'h004, 1, 12'h004, 1, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].stl, vecs[i].clr, vecs[i].npc, vecs[i].rdv, vecs[i].rpc);
            chk($sformatf("v%0d if_id_valid", i), 32'(if_id_valid),         32'(vecs[i].e_valid));
            chk($sformatf("v%0d if_id_pc", i),    32'(if_id_pc),            32'(vecs[i].e_pc));
            chk($sformatf("v%0d if_id_instr", i), if_id_instr,              vecs[i].e_instr);
            chk($sformatf("v%0d imem_addr", i),   32'(imem_addr),           32'(vecs[i].e_addr));
            chk($sformatf("v%0d imem_en", i),     32'(imem_en),             32'(vecs[i].e_en));
            chk($sformatf("v%0d next_cons_pc", i),32'(next_consecutive_pc), 32'(vecs[i].e_ncpc));
            chk($sformatf("v%0d fetch_count", i), 32'(fetch_count),         32'(vecs[i].e_fc));
            chk($sformatf("v%0d flush_count", i), 32'(flush_count),         32'(vecs[i].e_flc));
        end

        // Saturation: fetch_count is 1 here; 13 more fetches reach 14, then 15 and hold.
        for (int i = 0; i < 13; i++) step(1, 0, 0, 12'h000, 0, 12'h000);
        chk("sat fetch_count pre", 32'(fetch_count), 32'd14);
        for (int i = 0; i < 7; i++) step(1, 0, 0, 12'h000, 0, 12'h000);
        chk("sat fetch_count", 32'(fetch_count), 32'd15);
        chk("sat if_id_pc", 32'(if_id_pc), 32'h050);
        chk("sat flush_count", 32'(flush_count), 32'd0);

        // Flush counter saturation: 16 clear_if bubbles to a fixed target.
        for (int i = 0; i < 16; i++) step(1, 0, 1, 12'h080, 0, 12'h000);
        chk("sat flush_count", 32'(flush_count), 32'd15);
        chk("flush imem_addr", 32'(imem_addr), 32'h080);
        chk("flush if_id_valid", 32'(if_id_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
